// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared types for the two-port data-memory arbiter:
//   size_e  - access size encoding as it appears on req_size
//   state_e - sequencer states
//   req_t   - request record latched in the accept cycle
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        BYTE    = 2'd0,
        HALF    = 2'd1,
        WORD    = 2'd2,
        ILLEGAL = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    // The record keeps the address at a fixed generous width so one type
    // serves every ADDR_W up to this value; the top zero-extends into it.
    localparam int REQ_ADDR_W = 64;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
        logic                  wr;
        size_e                 size;
        logic                  uns;
    } req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align
// Purely combinational byte-lane steering for one 32-bit memory word.
//   size, off  - access size and byte offset within the word
//   wdata      - right-aligned store data
//   rdata      - raw word read from memory
//   uns        - 1 = zero-extend loads, 0 = sign-extend
//   we         - byte write-enable for the lanes touched (ungated)
//   wdata_rep  - store data replicated across all lanes
//   rdata_ext  - selected lane(s), right-aligned and extended
//   misalign   - offset not a multiple of the access size
module dmem_lane_align
    import dmem_arb_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        uns,
    output logic [3:0]  we,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[8*off +: 8];
    assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        we        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = rdata;
        misalign  = 1'b0;
        case (size)
            BYTE: begin
                we        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{~uns & byte_sel[7]}}, byte_sel};
            end
            HALF: begin
                misalign  = off[0];
                we        = 4'b0011 << off;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{~uns & half_sel[15]}}, half_sel};
            end
            WORD: begin
                misalign  = (off != 2'd0);
                we        = 4'b1111;
            end
            default: begin
                we        = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Round-robin arbiter and three-phase sequencer (IDLE -> ACCESS -> RESP)
// in front of a byte-lane data memory.
//   req_*      - per-port request channel; req_ready is the accept strobe
//   resp_*     - registered response; resp_valid marks the owning port
//   dmem_*     - word-aligned address, replicated write data, byte enables,
//                and the memory's combinational read word
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][31:0]       req_wdata,
    input  logic [1:0]             req_wr,
    input  logic [1:0][1:0]        req_size,
    input  logic [1:0]             req_unsigned,
    output logic [1:0]             resp_valid,
    input  logic [1:0]             resp_ready,
    output logic [31:0]            resp_rdata,
    output logic                   resp_err,
    output logic [ADDR_W-1:0]      dmem_addr,
    output logic [31:0]            dmem_wdata,
    output logic [3:0]             dmem_we,
    input  logic [31:0]            dmem_rdata
);

    localparam logic [REQ_ADDR_W-1:0] MEM_LIMIT = REQ_ADDR_W'(MEM_BYTES);

    state_e      state;
    logic        last_grant;
    logic        owner;
    req_t        lat;
    logic        winner;
    logic [1:0]  grant;
    logic [3:0]  lane_we;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        misalign;
    logic        err;

    // Round robin: on contention the port not granted last time wins.
    always_comb begin
        if (req_valid == 2'b11) winner = ~last_grant;
        else                    winner = ~req_valid[0];
    end

    // Ready is decoded from state so it is forced low while rst_n is low.
    always_comb begin
        grant = 2'b00;
        if (rst_n && state == IDLE && |req_valid) grant[winner] = 1'b1;
    end
    assign req_ready = grant;

    dmem_lane_align u_lane (
        .size      (lat.size),
        .off       (lat.addr[1:0]),
        .wdata     (lat.wdata),
        .rdata     (dmem_rdata),
        .uns       (lat.uns),
        .we        (lane_we),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata),
        .misalign  (misalign)
    );

    assign err = misalign || (lat.size == ILLEGAL) || (lat.addr >= MEM_LIMIT);

    // Enables come straight from the state register, so an async reset in
    // ACCESS removes them without waiting for an edge.
    assign dmem_we    = (state == ACCESS && lat.wr && !err) ? lane_we : 4'b0000;
    assign dmem_addr  = {lat.addr[ADDR_W-1:2], 2'b00};
    assign dmem_wdata = lane_wdata;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lat        <= '0;
            resp_valid <= 2'b00;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        lat.addr   <= REQ_ADDR_W'(req_addr[winner]);
                        lat.wdata  <= req_wdata[winner];
                        lat.wr     <= req_wr[winner];
                        lat.size   <= size_e'(req_size[winner]);
                        lat.uns    <= req_unsigned[winner];
                        owner      <= winner;
                        last_grant <= winner;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    resp_err   <= err;
                    resp_rdata <= (err || lat.wr) ? 32'h0 : lane_rdata;
                    resp_valid <= owner ? 2'b10 : 2'b01;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready[owner]) begin
                        resp_valid <= 2'b00;
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Self-checking bench: a byte-array memory behind the DUT, a transaction-level
// reference model checked every cycle, directed scenarios with literal
// expectations, then randomized traffic.
module tb_dmem_arbiter;

    localparam int MB = 128;
    localparam int AW = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][AW-1:0] req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        req_wr;
    logic [1:0][1:0]   req_size;
    logic [1:0]        req_unsigned;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [AW-1:0]     dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [3:0]        dmem_we;
    logic [31:0]       dmem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_BYTES(MB), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wr       (req_wr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_we      (dmem_we),
        .dmem_rdata   (dmem_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory behind the DUT ----------------
    logic [7:0] mem     [MB];
    logic [7:0] ref_mem [MB];

    always_comb begin
        dmem_rdata = 32'hA5A5_A5A5;
        if (dmem_addr < MB)
            dmem_rdata = {mem[int'(dmem_addr[6:0]) + 3], mem[int'(dmem_addr[6:0]) + 2],
                          mem[int'(dmem_addr[6:0]) + 1], mem[int'(dmem_addr[6:0])]};
    end

    always @(posedge clk) begin
        for (int j = 0; j < 4; j++)
            if (dmem_we[j] && dmem_addr < MB)
                mem[int'(dmem_addr[6:0]) + j] <= dmem_wdata[8*j +: 8];
    end

    // ---------------- transaction-level reference model ----------------
    int          m_phase = 0;   // 0 waiting for a grant, 1 memory cycle, 2 response
    int          m_last  = 1;
    int          m_owner = 0;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  m_size;
    logic        m_wr, m_uns, m_err;
    int          n_txn = 0;
    int          mon_win, mon_n, mon_off;
    logic [1:0]  mon_rdy;
    logic [3:0]  mon_we;
    logic [31:0] mon_wd;
    bit          mon_ok;

    function automatic bit legal_acc(input logic [31:0] a, input logic [1:0] s);
        int n;
        n = 1 << s;
        return (s != 2'd3) && ((a % n) == 0) && (a < MB);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_req_ready", req_ready, 2'b00);
            check("rst_resp_valid", resp_valid, 2'b00);
            check("rst_dmem_we", dmem_we, 4'h0);
            check("rst_resp_rdata", resp_rdata, 32'h0);
            check("rst_resp_err", resp_err, 1'b0);
            check("rst_dmem_addr", dmem_addr, 32'h0);
            check("rst_dmem_wdata", dmem_wdata, 32'h0);
            m_phase = 0;
            m_last  = 1;
        end else begin
            case (m_phase)
                0: begin
                    mon_win = (req_valid == 2'b11) ? 1 - m_last : (req_valid[0] ? 0 : 1);
                    mon_rdy = (req_valid == 2'b00) ? 2'b00 : ((mon_win == 0) ? 2'b01 : 2'b10);
                    check("idle_req_ready", req_ready, mon_rdy);
                    check("idle_dmem_we", dmem_we, 4'h0);
                    check("idle_resp_valid", resp_valid, 2'b00);
                    if (req_valid != 2'b00) begin
                        m_owner = mon_win;
                        m_last  = mon_win;
                        m_addr  = req_addr[mon_win];
                        m_wdata = req_wdata[mon_win];
                        m_wr    = req_wr[mon_win];
                        m_size  = req_size[mon_win];
                        m_uns   = req_unsigned[mon_win];
                        m_phase = 1;
                    end
                end
                1: begin
                    mon_n   = 1 << m_size;
                    mon_off = int'(m_addr % 4);
                    mon_ok  = legal_acc(m_addr, m_size);
                    mon_we  = 4'h0;
                    mon_wd  = 32'h0;
                    if (mon_ok && m_wr)
                        for (int i = 0; i < mon_n; i++) mon_we[mon_off + i] = 1'b1;
                    for (int j = 0; j < 4; j++) mon_wd[8*j +: 8] = m_wdata[8*(j % mon_n) +: 8];
                    check("acc_dmem_we", dmem_we, mon_we);
                    check("acc_dmem_addr", dmem_addr, m_addr & ~32'h3);
                    if (mon_ok && m_wr) check("acc_dmem_wdata", dmem_wdata, mon_wd);
                    check("acc_req_ready", req_ready, 2'b00);
                    check("acc_resp_valid", resp_valid, 2'b00);
                    m_err   = !mon_ok;
                    m_rdata = 32'h0;
                    if (mon_ok && !m_wr) begin
                        for (int i = 0; i < mon_n; i++) m_rdata[8*i +: 8] = ref_mem[int'(m_addr) + i];
                        if (!m_uns && mon_n < 4 && m_rdata[8*mon_n - 1])
                            m_rdata = m_rdata | ~((32'h1 << (8*mon_n)) - 32'h1);
                    end
                    if (mon_ok && m_wr)
                        for (int i = 0; i < mon_n; i++) ref_mem[int'(m_addr) + i] = m_wdata[8*i +: 8];
                    n_txn++;
                    m_phase = 2;
                end
                default: begin
                    check("resp_valid_owner", resp_valid, (m_owner == 1) ? 2'b10 : 2'b01);
                    check("resp_rdata", resp_rdata, m_rdata);
                    check("resp_err", resp_err, m_err);
                    check("resp_req_ready", req_ready, 2'b00);
                    check("resp_dmem_we", dmem_we, 4'h0);
                    if (resp_ready[m_owner]) m_phase = 0;
                end
            endcase
        end
    end

    // ---------------- directed transaction helper ----------------
    task automatic drain(input int q);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (!req_ready[q] && k < 20);
        check("drain_grant", req_ready[q], 1'b1);
        @(posedge clk); #1 req_valid[q] = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!resp_valid[q] && k < 20);
        check("drain_resp", resp_valid[q], 1'b1);
        @(posedge clk); #1 resp_ready[q] = 1'b1;
        @(posedge clk); #1 resp_ready[q] = 1'b0;
    endtask

    task automatic txn(input int p, input logic [31:0] a, input logic [31:0] wd, input logic w,
                       input logic [1:0] sz, input logic u, input int hold, input bit other,
                       output logic [31:0] rd, output logic er, output logic [3:0] we_or,
                       output int we_cyc, output logic [31:0] wd_seen);
        int k;
        int q;
        logic [31:0] rd0;
        logic        er0;
        q = 1 - p;
        we_or = 4'h0; we_cyc = 0; wd_seen = 32'h0; rd = 32'h0; er = 1'b0;
        @(posedge clk); #1;
        req_addr[p] = a; req_wdata[p] = wd; req_wr[p] = w;
        req_size[p] = sz; req_unsigned[p] = u; req_valid[p] = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!req_ready[p] && k < 20);
        check("txn_grant", req_ready[p], 1'b1);
        @(posedge clk); #1 req_valid[p] = 1'b0;
        if (other) begin
            req_addr[q] = 32'h10; req_wr[q] = 1'b0; req_size[q] = 2'd2;
            req_unsigned[q] = 1'b0; req_valid[q] = 1'b1;
        end
        k = 0;
        do begin
            @(negedge clk); k++;
            if (dmem_we != 4'h0) begin we_or |= dmem_we; we_cyc++; wd_seen = dmem_wdata; end
        end while (!resp_valid[p] && k < 20);
        check("txn_resp", resp_valid[p], 1'b1);
        rd0 = resp_rdata; er0 = resp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            if (dmem_we != 4'h0) begin we_or |= dmem_we; we_cyc++; end
            check("bp_resp_valid", resp_valid, (p == 1) ? 2'b10 : 2'b01);
            check("bp_resp_rdata", resp_rdata, rd0);
            check("bp_resp_err", resp_err, er0);
            if (other) check("bp_other_ready", req_ready[q], 1'b0);
        end
        rd = rd0; er = er0;
        @(posedge clk); #1 resp_ready[p] = 1'b1;
        @(posedge clk); #1 resp_ready[p] = 1'b0;
        if (other) drain(q);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rd, pre;
    logic        er;
    logic [3:0]  we_or;
    int          we_cyc, k;
    logic [31:0] wd_seen;

    logic [31:0] e_addr [5] = '{32'h05, 32'h03, 32'h80, 32'h00, 32'h05};
    logic [1:0]  e_size [5] = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd2};
    logic        e_wr   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        req_valid = 2'b11; req_addr = '0; req_wdata = '0; req_wr = '0;
        req_size = '0; req_unsigned = '0; resp_ready = 2'b00;
        for (int i = 0; i < MB; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(posedge clk);
        #1 check("reset_forces_ready_low", req_ready, 2'b00);
        req_valid = 2'b00;
        @(posedge clk); #1 rst_n = 1'b1;

        // word store then sub-word loads
        txn(0, 32'h10, 32'hDEADBEEF, 1'b1, 2'd2, 1'b0, 0, 1'b0, rd, er, we_or, we_cyc, wd_seen);
        check("st_word_we", we_or, 4'b1111);
        check("st_word_we_cycles", we_cyc, 1);
        check("st_word_err", er, 1'b0);
        txn(0, 32'h13, 32'h0, 1'b0, 2'd0, 1'b0, 0, 1'b0, rd, er, we_or, we_cyc, wd_seen);
        check("ld_byte_signed", rd, 32'hFFFFFFDE);
        txn(0, 32'h13, 32'h0, 1'b0, 2'd0, 1'b1, 0, 1'b0, rd, er, we_or, we_cyc, wd_seen);
        check("ld_byte_unsigned", rd, 32'h000000DE);
        txn(0, 32'h12, 32'h0, 1'b0, 2'd1, 1'b0, 0, 1'b0, rd, er, we_or, we_cyc, wd_seen);
        check("ld_half_signed", rd, 32'hFFFFDEAD);
        check("ld_no_we", we_or, 4'h0);

        // half store on port 1
        txn(1, 32'h22, 32'h00001234, 1'b1, 2'd1, 1'b0, 0, 1'b0, rd, er, we_or, we_cyc, wd_seen);
        check("st_half_we", we_or, 4'b1100);
        check("st_half_wdata", wd_seen, 32'h12341234);
        txn(1, 32'h20, 32'h0, 1'b0, 2'd2, 1'b0, 0, 1'b0, rd, er, we_or, we_cyc, wd_seen);
        check("ld_word_upper_half", rd[31:16], 16'h1234);

        // error cases
        for (int i = 0; i < 5; i++) begin
            txn(0, e_addr[i], 32'hFFFF_FFFF, e_wr[i], e_size[i], 1'b0, 0, 1'b0,
                rd, er, we_or, we_cyc, wd_seen);
            check($sformatf("err%0d_flag", i), er, 1'b1);
            check($sformatf("err%0d_rdata", i), rd, 32'h0);
            check($sformatf("err%0d_we", i), we_or, 4'h0);
        end

        // response backpressure with the other port requesting
        txn(0, 32'h10, 32'h0, 1'b0, 2'd2, 1'b0, 3, 1'b1, rd, er, we_or, we_cyc, wd_seen);
        check("bp_rdata_value", rd, 32'hDEADBEEF);

        // reset during the memory cycle of a store
        pre = {ref_mem[8'h43], ref_mem[8'h42], ref_mem[8'h41], ref_mem[8'h40]};
        @(posedge clk); #1;
        req_addr[0] = 32'h40; req_wdata[0] = 32'hCAFEF00D; req_wr[0] = 1'b1;
        req_size[0] = 2'd2; req_unsigned[0] = 1'b0; req_valid[0] = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!req_ready[0] && k < 20);
        check("rst_test_grant", req_ready[0], 1'b1);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        #1 check("rst_test_we_before", dmem_we, 4'b1111);
        rst_n = 1'b0;
        #1 check("rst_test_we_async_drop", dmem_we, 4'h0);
        check("rst_test_no_resp", resp_valid, 2'b00);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;

        // contention straight after reset: port 0 first, then alternate
        req_addr[0] = 32'h10; req_wr[0] = 1'b0; req_size[0] = 2'd2;
        req_addr[1] = 32'h20; req_wr[1] = 1'b0; req_size[1] = 2'd2;
        req_valid = 2'b11; resp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            do begin @(negedge clk); k++; end while (req_ready == 2'b00 && k < 20);
            check($sformatf("contention_grant%0d", i), req_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
            @(posedge clk);
        end
        #1 req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1 resp_ready = 2'b00;

        txn(0, 32'h40, 32'h0, 1'b0, 2'd2, 1'b0, 0, 1'b0, rd, er, we_or, we_cyc, wd_seen);
        check("rst_test_store_dropped", rd, pre);

        // randomized traffic, checked by the model every cycle
        k = n_txn;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                req_valid[p]    = ($urandom_range(0, 2) != 0);
                req_wr[p]       = 1'($urandom_range(0, 1));
                req_size[p]     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                req_unsigned[p] = 1'($urandom_range(0, 1));
                req_wdata[p]    = $urandom;
                req_addr[p]     = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, MB + 15));
                if ($urandom_range(0, 1) == 1 && req_size[p] != 2'd3)
                    req_addr[p] = req_addr[p] & ~((32'h1 << req_size[p]) - 32'h1);
                resp_ready[p]   = ($urandom_range(0, 3) != 0);
            end
        end
        @(posedge clk); #1 req_valid = 2'b00; resp_ready = 2'b11;
        repeat (10) @(posedge clk);
        check("random_activity", (n_txn - k) > 500, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the byte-lane data memory. It accepts load/store requests from two requesters (port 0: core load/store unit, port 1: DMA/debug), grants them round-robin and expands byte/half/word sizes into lane write-enables and replicated write data. It extracts and sign/zero-extends read data and returns a registered response with an error flag. It sits between the requesters and the data memory, driving the memory's word-aligned address, write data and 4-bit byte write-enable.

## Interface
Parameters:
- `MEM_BYTES`, default 128: memory size in bytes. An access is out of range when `addr >= MEM_BYTES`.
- `ADDR_W`, default 32: address width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, [1:0]: request valid per port.
- `req_ready`, out, [1:0]: request accepted this cycle, per port.
- `req_addr`, in, [1:0][ADDR_W-1:0]: byte address.
- `req_wdata`, in, [1:0][31:0]: store data, right-aligned.
- `req_wr`, in, [1:0]: 1 = store, 0 = load.
- `req_size`, in, [1:0][1:0]: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned`, in, [1:0]: 1 = zero-extend loads, 0 = sign-extend loads.
- `resp_valid`, out, [1:0]: response valid, asserted only for the port that owns the transaction.
- `resp_ready`, in, [1:0]: response consumed.
- `resp_rdata`, out, [31:0]: load result, right-aligned and extended. 0 for stores and errors.
- `resp_err`, out, 1: misaligned, illegal-size or out-of-range access.
- `dmem_addr`, out, [ADDR_W-1:0]: request address with bits [1:0] forced to 0.
- `dmem_wdata`, out, [31:0]: lane-replicated write data.
- `dmem_we`, out, [3:0]: byte write-enable.
- `dmem_rdata`, in, [31:0]: combinational read word from the memory.

## Operation
- FSM with three states: IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE**
  - If any `req_valid` is high, pick the winner and assert `req_ready` for that port only. This is combinational in IDLE.
  - Latch addr, wdata, wr, size, unsigned and owner, then go to ACCESS.
  - With no request, stay in IDLE.
- **Arbitration**
  - A `last_grant` register resets to 1, so port 0 wins the first contest.
  - When both ports are valid, the port other than `last_grant` wins.
  - When one port is valid, it wins. `last_grant` updates on every grant.
- **ACCESS** (exactly one cycle)
  - Drive `dmem_addr` from the latched address.
  - For a legal store, drive `dmem_we` and `dmem_wdata` as listed under Lane rules.
  - For a load, capture the extracted `dmem_rdata`.
  - Compute the error flag, then go to RESP.
- **RESP**
  - Hold `resp_valid[owner]=1` with `resp_rdata` and `resp_err` stable until `resp_ready[owner]=1`, then return to IDLE.
  - No new grant is made while in RESP.
- **Lane rules** (`off = addr[1:0]`)
  - Byte: `we = 4'b0001 << off`, `wdata = {4{wdata[7:0]}}`. Load result is byte `off`, extended.
  - Half: legal only for `off` = 0 or 2. `we = 4'b0011 << off`, `wdata = {2{wdata[15:0]}}`. Load result is half `off[1]`, extended.
  - Word: legal only for `off` = 0. `we = 4'b1111`, wdata passes through. Load result is the full word.
- **Errors**
  - Causes: misaligned access, `size == 3`, or out of range.
  - Effects: `dmem_we` stays 0, `resp_err = 1` and `resp_rdata = 0`.
- **Idle outputs**: `dmem_we` is 0 in every state except ACCESS. `dmem_addr` and `dmem_wdata` are don't-care outside ACCESS but are held at the latched values.

## Timing
- Request accepted in cycle 0 (IDLE). Memory access in cycle 1 (ACCESS). `resp_valid` is high from cycle 2.
- Best-case throughput is one transaction per 3 cycles.
- Reset values: state IDLE, `last_grant` = 1, and `req_ready`, `resp_valid`, `resp_err`, `resp_rdata`, `dmem_we`, `dmem_addr`, `dmem_wdata` all 0.
- While `rst_n` is low, `req_ready` is forced to 0.
- Reset asserted mid-transaction:
  - The FSM returns to IDLE immediately and `dmem_we` drops to 0 asynchronously.
  - The in-flight transaction is dropped with no response.
- Port inputs are sampled only in the accept cycle. Changes after the handshake have no effect.
- `resp_ready` asserted on the first RESP cycle gives a return to IDLE on the next edge. A new grant can happen in that IDLE cycle.

## Structure
- Package `dmem_arb_pkg`:
  - `size_e` enum: BYTE, HALF, WORD, ILLEGAL.
  - `state_e` enum: IDLE, ACCESS, RESP.
  - Typedef for a request record (addr, wdata, wr, size, unsigned).
- Sub-module `dmem_lane_align`, purely combinational:
  - Inputs: size, offset, wdata, rdata, unsigned.
  - Outputs: we, replicated wdata, extracted rdata, misalign flag.
  - The top level holds the FSM, the arbiter and the registers.

## Test plan
- **Word store then sub-word loads.** Port 0 stores word 0xDEADBEEF to 0x10.
  - Required: `dmem_we=1111` for exactly one cycle, then `resp_err=0`.
  - Signed byte load from 0x13 returns 0xFFFFFFDE. Unsigned byte load returns 0x000000DE. Half load from 0x12 returns 0xFFFFDEAD.
- **Half store.** Port 1 stores half 0x1234 to 0x22.
  - Required: in ACCESS, `dmem_we=1100` and `dmem_wdata=0x12341234`. A word load from 0x20 then shows 0x1234 in the upper half.
- **Contention.** Both ports hold `req_valid` for 4 transactions.
  - Required: grant order 0, 1, 0, 1, and `resp_valid` only ever on the owning port.
- **Error cases.** Word access at 0x05, half at 0x03, byte at 0x80 and `size=3`.
  - Required for each: `resp_err=1`, `resp_rdata=0`, and `dmem_we` never nonzero.
- **Response backpressure.** Hold `resp_ready` low for 3 cycles.
  - Required: `resp_valid` and data stay stable, and `req_ready` stays 0 for the other port throughout.
- **Reset mid-access.** Drop `rst_n` during the ACCESS cycle of a store.
  - Required: `dmem_we` goes to 0 before the next edge, no response is issued, and after release port 0 wins the first contest.
